// File: rtl/traffic_light_sequencer.sv
// Traffic light sequencer: counts timer ticks to step main/side/pedestrian phases,
// latches pedestrian requests and pulses ped_ack on the first WALK cycle.
module traffic_light_sequencer #(
    parameter int GREEN_TICKS  = 4,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 1,
    parameter int WALK_TICKS   = 3,
    parameter int CNT_W        = 4
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic       enable_L,
    input  logic       enable_P,
    input  logic       ped_req,
    output logic [2:0] main_lt,
    output logic [2:0] side_lt,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_MG   = 3'd0,
        S_MY   = 3'd1,
        S_AR1  = 3'd2,
        S_SG   = 3'd3,
        S_SY   = 3'd4,
        S_AR2  = 3'd5,
        S_WALK = 3'd6
    } state_t;

    // Last dwell value of each phase; the advancing tick arrives while dwell holds it
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_TICKS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic             pend_q, pend_d;
    logic             ack_q, ack_d;

    logic             tick;
    logic [CNT_W-1:0] last;
    state_t           next_phase;
    logic             enter_walk;

    // State, dwell counter, pending request and ack registers
    always_ff @(posedge clk) begin
        if (rst_a) begin
            state_q <= S_MG;
            dwell_q <= '0;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
        end
    end

    // Next-state: pick the relevant tick and dwell limit, advance on the final tick
    always_comb begin
        state_d    = state_q;
        dwell_d    = dwell_q;
        tick       = 1'b0;
        last       = GREEN_LAST;
        next_phase = S_MG;

        // WALK counts pedestrian ticks; every vehicle phase counts vehicle ticks
        tick = (state_q == S_WALK) ? enable_P : enable_L;

        case (state_q)
            S_MG:    begin last = GREEN_LAST;  next_phase = S_MY;  end
            S_MY:    begin last = YELLOW_LAST; next_phase = S_AR1; end
            S_AR1:   begin last = ALLRED_LAST; next_phase = S_SG;  end
            S_SG:    begin last = GREEN_LAST;  next_phase = S_SY;  end
            S_SY:    begin last = YELLOW_LAST; next_phase = S_AR2; end
            S_AR2:   begin last = ALLRED_LAST; next_phase = pend_q ? S_WALK : S_MG; end
            S_WALK:  begin last = WALK_LAST;   next_phase = S_MG;  end
            default: begin last = '0;          next_phase = S_MG;  end
        endcase

        if (tick) begin
            if (dwell_q == last) begin
                state_d = next_phase;
                dwell_d = '0;
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
        end
    end

    // Pending request: entering WALK clears it even if the button is held on that edge
    always_comb begin
        enter_walk = (state_d == S_WALK) && (state_q != S_WALK);
        pend_d     = pend_q;
        ack_d      = enter_walk;
        if (enter_walk)
            pend_d = 1'b0;
        else if (ped_req && state_q != S_WALK)
            pend_d = 1'b1;
    end

    // Moore lamp decode from the registered state
    always_comb begin
        main_lt = 3'b100;
        side_lt = 3'b100;
        walk    = 1'b0;
        case (state_q)
            S_MG:    main_lt = 3'b001;
            S_MY:    main_lt = 3'b010;
            S_SG:    side_lt = 3'b001;
            S_SY:    side_lt = 3'b010;
            S_WALK:  walk    = 1'b1;
            default: ;
        endcase
    end

    assign ped_ack = ack_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Bench for traffic_light_sequencer: table vectors, hand sequences and a random
// soak, all checked through an expected-result queue against a countdown model.
module tb_traffic_light_sequencer;

    logic       clk;
    logic       rst_a, enable_L, enable_P, ped_req;
    logic [2:0] main_lt, side_lt, state_o;
    logic       walk, ped_ack;

    traffic_light_sequencer dut (
        .clk     (clk),
        .rst_a   (rst_a),
        .enable_L(enable_L),
        .enable_P(enable_P),
        .ped_req (ped_req),
        .main_lt (main_lt),
        .side_lt (side_lt),
        .walk    (walk),
        .ped_ack (ped_ack),
        .state_o (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, el, ep, pr;
        logic [2:0] st;
        logic       ack;
    } vec_t;

    typedef struct {
        logic [2:0] st;
        logic       ack;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Countdown model: ticks remaining in the current phase
    logic [2:0] m_st;
    int         m_rem;
    logic       m_pend, m_ack;

    function automatic int ticks_of(input logic [2:0] s);
        case (s)
            3'd0, 3'd3: return 4;
            3'd1, 3'd4: return 2;
            3'd2, 3'd5: return 1;
            default:    return 3;
        endcase
    endfunction

    // Lamp table {main, side} per state
    function automatic logic [5:0] lamps_of(input logic [2:0] s);
        case (s)
            3'd0:    return {3'b001, 3'b100};
            3'd1:    return {3'b010, 3'b100};
            3'd3:    return {3'b100, 3'b001};
            3'd4:    return {3'b100, 3'b010};
            default: return {3'b100, 3'b100};
        endcase
    endfunction

    task automatic model_step(input logic r, l, p, q);
        logic [2:0] nxt;
        logic       tk;
        if (r) begin
            m_st = 3'd0; m_rem = 4; m_pend = 1'b0; m_ack = 1'b0;
        end else begin
            nxt = m_st;
            tk  = (m_st == 3'd6) ? p : l;
            if (tk) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    case (m_st)
                        3'd5:    nxt = m_pend ? 3'd6 : 3'd0;
                        3'd6:    nxt = 3'd0;
                        default: nxt = m_st + 3'd1;
                    endcase
                    m_rem = ticks_of(nxt);
                end
            end
            m_ack = (nxt == 3'd6) && (m_st != 3'd6);
            if (m_ack)                  m_pend = 1'b0;
            else if (q && m_st != 3'd6) m_pend = 1'b1;
            m_st = nxt;
        end
    endtask

    int acks = 0, walk_entries = 0;
    logic [2:0] prev_st = 3'd0;

    // Drive one cycle, queue the expectation, compare after the edge
    task automatic cycle(input string name, input logic r, l, p, q,
                         input logic use_tbl, input logic [2:0] tst, input logic tack);
        exp_t e;
        exp_t got;
        logic [5:0] lp;
        logic bad;
        rst_a = r; enable_L = l; enable_P = p; ped_req = q;
        model_step(r, l, p, q);
        e.st  = use_tbl ? tst  : m_st;
        e.ack = use_tbl ? tack : m_ack;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        lp  = lamps_of(got.st);
        bad = (state_o !== got.st) || (ped_ack !== got.ack) ||
              (main_lt !== lp[5:3]) || (side_lt !== lp[2:0]) ||
              (walk !== (got.st == 3'd6)) ||
              (main_lt != 3'b100 && side_lt != 3'b100) ||
              (walk && (main_lt != 3'b100 || side_lt != 3'b100)) ||
              !$onehot(main_lt) || !$onehot(side_lt);
        n_vec++;
        if (bad) begin
            n_miss++;
            $display("FAIL %s #%0d: got st=%0d main=%b side=%b walk=%b ack=%b, want st=%0d main=%b side=%b walk=%b ack=%b",
                     name, n_vec, state_o, main_lt, side_lt, walk, ped_ack,
                     got.st, lp[5:3], lp[2:0], (got.st == 3'd6), got.ack);
        end
        if (ped_ack) acks++;
        if (state_o == 3'd6 && prev_st != 3'd6) walk_entries++;
        prev_st = state_o;
    endtask

    vec_t tbl[$];

    initial begin
        logic [2:0] exp14 [14];
        vec_t v;
        rst_a = 1'b1; enable_L = 1'b0; enable_P = 1'b0; ped_req = 1'b0;
        m_st = 3'd0; m_rem = 4; m_pend = 1'b0; m_ack = 1'b0;

        // Full vehicle cycle, one enable_L per vector, then corner vectors
        exp14 = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3,
                  3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd0};
        v = '{rst:1'b1, el:1'b0, ep:1'b0, pr:1'b0, st:3'd0, ack:1'b0};
        tbl.push_back(v);
        for (int i = 0; i < 14; i++) begin
            v = '{rst:1'b0, el:1'b1, ep:1'b0, pr:1'b0, st:exp14[i], ack:1'b0};
            tbl.push_back(v);
        end
        // enable_P outside WALK does nothing
        v = '{rst:1'b0, el:1'b0, ep:1'b1, pr:1'b0, st:3'd0, ack:1'b0}; tbl.push_back(v);
        v = '{rst:1'b0, el:1'b1, ep:1'b1, pr:1'b0, st:3'd0, ack:1'b0}; tbl.push_back(v);
        v = '{rst:1'b0, el:1'b1, ep:1'b0, pr:1'b0, st:3'd0, ack:1'b0}; tbl.push_back(v);
        // reset wins over enable_L on the same edge (dwell is 2 here)
        v = '{rst:1'b1, el:1'b1, ep:1'b0, pr:1'b0, st:3'd0, ack:1'b0}; tbl.push_back(v);
        v = '{rst:1'b0, el:1'b1, ep:1'b0, pr:1'b0, st:3'd0, ack:1'b0}; tbl.push_back(v);
        v = '{rst:1'b0, el:1'b1, ep:1'b0, pr:1'b0, st:3'd0, ack:1'b0}; tbl.push_back(v);
        v = '{rst:1'b0, el:1'b1, ep:1'b0, pr:1'b0, st:3'd0, ack:1'b0}; tbl.push_back(v);
        v = '{rst:1'b0, el:1'b1, ep:1'b0, pr:1'b0, st:3'd1, ack:1'b0}; tbl.push_back(v);

        foreach (tbl[i])
            cycle("table", tbl[i].rst, tbl[i].el, tbl[i].ep, tbl[i].pr, 1'b1, tbl[i].st, tbl[i].ack);

        // Pedestrian request in MG leads to WALK after AR2, held button on entry
        cycle("ped_rst", 1, 0, 0, 0, 0, 0, 0);
        cycle("ped_req", 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 13; i++) cycle("ped_cycle", 0, 1, 0, 0, 0, 0, 0);
        cycle("walk_entry", 0, 1, 0, 1, 1, 3'd6, 1'b1);
        cycle("walk_ackdrop", 0, 1, 0, 1, 1, 3'd6, 1'b0);
        cycle("walk_L_ign", 0, 1, 0, 0, 1, 3'd6, 1'b0);
        cycle("walk_P1", 0, 1, 1, 0, 1, 3'd6, 1'b0);
        cycle("walk_P2", 0, 0, 1, 0, 1, 3'd6, 1'b0);
        cycle("walk_P3", 0, 0, 1, 0, 1, 3'd0, 1'b0);
        // Held button on WALK entry must not leave a request pending
        for (int i = 0; i < 14; i++) cycle("no_rewalk", 0, 1, 0, 0, 0, 0, 0);

        // Reset in SY with a pending request discards it
        cycle("sy_req", 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 11; i++) cycle("to_sy", 0, 1, 0, 0, 0, 0, 0);
        cycle("in_sy", 0, 0, 0, 0, 1, 3'd4, 1'b0);
        cycle("sy_reset", 1, 1, 0, 0, 1, 3'd0, 1'b0);
        for (int i = 0; i < 14; i++) cycle("post_rst", 0, 1, 0, 0, 0, 0, 0);
        cycle("post_rst_mg", 0, 0, 0, 0, 1, 3'd0, 1'b0);

        // Random soak
        acks = 0; walk_entries = 0;
        for (int i = 0; i < 10000; i++)
            cycle("random", ($urandom_range(0, 999) == 0), $urandom_range(0, 1),
                  $urandom_range(0, 1), ($urandom_range(0, 7) == 0), 0, 0, 0);

        n_vec++;
        if (acks != walk_entries || walk_entries == 0) begin
            n_miss++;
            $display("FAIL ack_count: got %0d acks, want %0d (walk entries, nonzero)", acks, walk_entries);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
